// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Used by imem_boot_loader and byte_assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader is still consuming stream bytes.
  function automatic logic is_receiving(input loader_state_e st);
    return (st == LEN_LO) || (st == LEN_HI) || (st == DATA) || (st == CSUM);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is a
// combinational strobe on the byte that completes a word.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q,   cnt_d;

  // First byte drifts down to bits [7:0] after four shifts.
  assign word       = {byte_in, shift_q[31:8]};
  assign word_valid = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (byte_en) begin
      shift_d = word;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a length-prefixed byte stream, then releases
// the core reset. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [16:0]     DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_DATA = CSUM;
`else
  localparam loader_state_e AFTER_DATA = DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic              asm_en;
  logic [15:0]       len_word;
  logic [31:0]       asm_word;
  logic              asm_word_valid;

  assign in_ready = is_receiving(state_q);
  assign accept   = in_valid && in_ready;
  assign len_word = {in_data, len_lo_q};

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (asm_en),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    done_d       = done_q;
    err_d        = err_q;
    asm_en       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept) begin
          if (len_word == 16'd0) begin
            state_d = AFTER_DATA;
          end else if ({1'b0, len_word} > DEPTH_L) begin
            state_d = ERR;
          end else begin
            len_d   = len_word[ADDR_W:0];
            state_d = DATA;
          end
        end
      end

      DATA: begin
        asm_en = accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ in_data;
`endif
        if (asm_word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_cnt_q[ADDR_W-1:0];
          imem_wdata_d = asm_word;
          word_cnt_d   = word_cnt_q + ONE;
          if (word_cnt_d == len_q) state_d = AFTER_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      end
`endif

      // Release one edge after entry so the last write has already landed.
      DONE: begin
        cpu_rst_d = 1'b0;
        done_d    = 1'b1;
      end

      ERR: begin
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
      end

      default: state_d = ERR;
    endcase

    if (state_d == ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LEN_LO;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_boot_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] img[8];
  logic [7:0]  exp_csum;

  // Each imem_we pulse lasts exactly one cycle, so one negedge sees it once.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    exp_csum = 8'h00;
    rst = 1'b0;
  endtask

  // Returns at 1 ns after the accepting edge (plus gap idle cycles).
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_words(input int n, input int gap_max);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] wd;
        logic [7:0]  b;
        wd = img[w];
        b  = wd[8*k +: 8];
        exp_csum = exp_csum ^ b;
        send_byte(b, (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
      end
    end
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], 32'(i));
      check({tag, "_data"}, wr_data[i], img[i]);
    end
  endtask

  initial begin
    // Reset values
    do_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // N=2, two RISC-V instructions
    do_reset();
    img[0] = 32'h0000_0513;
    img[1] = 32'h0010_0593;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_words(2, 0);
    check("n2_we_last", 32'(imem_we), 32'd1);
    check("n2_cpu_rst_during_wr", 32'(cpu_rst), 32'd1);
    check("n2_done_early", 32'(done), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("n2_ready_csum", 32'(in_ready), 32'd1);
    send_byte(exp_csum, 0);
`endif
    check("n2_done_not_yet", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("n2_cpu_rst", 32'(cpu_rst), 32'd0);
    check("n2_done", 32'(done), 32'd1);
    check("n2_in_ready", 32'(in_ready), 32'd0);
    check("n2_addr_hold", 32'(imem_addr), 32'd1);
    check("n2_wdata_hold", imem_wdata, 32'h0010_0593);
    check_writes("n2", 2);
    $display("frame N=2: %0d writes, done=%0b", wr_addr.size(), done);

    // N=0
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    repeat (2) @(posedge clk);
    #1;
    check("n0_wait_csum", 32'(done), 32'd0);
    check("n0_ready_csum", 32'(in_ready), 32'd1);
    send_byte(8'h00, 0);
`endif
    check("n0_done_first", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("n0_done", 32'(done), 32'd1);
    check("n0_cpu_rst", 32'(cpu_rst), 32'd0);
    check("n0_nwr", 32'(wr_addr.size()), 32'd0);
    $display("frame N=0: done=%0b cpu_rst=%0b", done, cpu_rst);

    // N=DEPTH+1 rejected
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ovf_err_sticky", 32'(err), 32'd1);
    check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_nwr", 32'(wr_addr.size()), 32'd0);
    $display("frame N=0x0401: err=%0b", err);

    // N=DEPTH exactly is accepted into DATA
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    check("depth_ok_err", 32'(err), 32'd0);
    check("depth_ok_ready", 32'(in_ready), 32'd1);
    $display("frame N=0x0400 header: err=%0b", err);

    // N=3 with random valid gaps
    do_reset();
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h1234_5678;
    img[2] = 32'hA5A5_0001;
    send_byte(8'h03, 1);
    send_byte(8'h00, 2);
    send_words(3, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("gap_done", 32'(done), 32'd1);
    check_writes("gap", 3);
    $display("frame N=3 gapped: %0d writes", wr_addr.size());

    // Reset in the middle of an N=4 load, then a fresh N=1 image
    do_reset();
    img[0] = 32'h0403_0201;
    img[1] = 32'h0807_0605;
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] wd;
      wd = img[i / 4];
      send_byte(wd[8*(i%4) +: 8], 0);
      check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    end
    check("abort_pre_nwr", 32'(wr_addr.size()), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_cpu_rst_async", 32'(cpu_rst), 32'd1);
    check("abort_wdata_rst", imem_wdata, 32'd0);
    check("abort_ready_rst", 32'(in_ready), 32'd1);
    do_reset();
    img[0] = 32'hCAFE_F00D;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_words(1, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("restart_done", 32'(done), 32'd1);
    check_writes("restart", 1);
    $display("frame N=1 after abort: %0d writes", wr_addr.size());

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum pass and fail
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      img[0] = 32'h0804_0201;
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_words(1, 0);
      check("cs_model", 32'(exp_csum), 32'h0F);
      send_byte((pass == 0) ? 8'h0F : 8'h0E, 0);
      @(posedge clk); #1;
      check("cs_done", 32'(done), (pass == 0) ? 32'd1 : 32'd0);
      check("cs_err", 32'(err), (pass == 0) ? 32'd0 : 32'd1);
      check("cs_cpu_rst", 32'(cpu_rst), (pass == 0) ? 32'd0 : 32'd1);
      check_writes("cs", 1);
      $display("frame N=1 checksum case %0d: done=%0b err=%0b", pass, done, err);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle RISC-V core: fills instruction memory from a byte stream, then releases the core from reset.
- Accepts a framed byte stream over a valid/ready handshake and packs bytes into 32-bit little-endian words.
- Writes each word to instruction memory through a synchronous write port.
- Holds the core's reset (cpu_rst) asserted until the image is complete, then deasserts it.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words.
- ADDR_W, 10, word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  reset to the core; active-high.
- done  out  1  image loaded and core released.
- err  out  1  load failed; sticky until rst.

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where in_valid && in_ready.
- Reset values: state LEN_LO, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, byte counter=0, word counter=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, least significant byte first.
- State LEN_LO: accept a byte, store it in N[7:0], go to LEN_HI.
- State LEN_HI: accept a byte into N[15:8], then branch on the full N:
  - N==0: go to DONE.
  - N>DEPTH: go to ERR.
  - otherwise: go to DATA.
- State DATA: bytes shift into a 32-bit assembly register and a 2-bit byte counter increments.
- Word write: on the edge accepting byte 3 of a word, the registers load imem_we=1, imem_addr=word counter and imem_wdata=assembled word; the word counter increments.
- imem_we is high for exactly that following cycle; imem_addr and imem_wdata hold their last value afterwards.
- On the edge accepting the last byte of word N-1, the state moves to DONE (or to CSUM, see Optional Feature).
- in_ready stays 1 during DATA; back-to-back bytes cause no stall and at most one write per four bytes.
- State DONE: in_ready=0. cpu_rst clears and done sets on the first edge after entering DONE, so the final write has completed before the core runs. Terminal until rst.
- State ERR: in_ready=0, err=1, cpu_rst stays 1, done=0. Terminal until rst.
- Counters: the word counter is ADDR_W+1 bits and never wraps, because N<=DEPTH is checked before DATA. The byte counter wraps 3->0.
- Idle stream: in_valid low stalls every state indefinitely with no side effects.
- Reset mid-load: all state, counters, and outputs return to reset values asynchronously. cpu_rst reasserts immediately. Partially written memory contents are left as they are.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (length bytes excluded) is kept.
  - After the last data byte the state moves to CSUM and accepts one checksum byte.
  - Match: go to DONE. Mismatch: go to ERR.
  - N==0 also passes through CSUM; the expected checksum is 0x00.
- Undefined: no CSUM state and no XOR register; the last data byte leads directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR;
  - the LEN_BYTES=2 constant;
  - the BYTES_PER_WORD=4 constant.
- Sub-module byte_assembler:
  - contents: 32-bit shift register, 2-bit byte counter, word_valid pulse output.
  - reuse: intended for later data-memory loaders.

Test Plan:
- Send N=2 with bytes 13 05 00 00 93 05 10 00 -> imem_we pulses with addr0=0x00000513, then addr1=0x00100593. cpu_rst falls one cycle after the second write cycle; done=1.
- Send N=0 -> no imem_we pulse. Without the checksum feature, done=1 and cpu_rst=0 two edges after LEN_HI is accepted. With the feature, done=1 only after byte 0x00 is sent.
- Send N=DEPTH+1 (DEPTH=1024, so N=0x0401) -> err=1, in_ready=0, cpu_rst stays 1, no writes.
- Random in_valid gaps during a 3-word image -> the same three writes occur at addresses 0,1,2; no extra or duplicated imem_we pulses.
- Assert rst after 6 data bytes of N=4, then send a full N=1 image -> the write goes to address 0 and the counters restart; cpu_rst was high throughout the aborted load.
- With IMEM_LOADER_CHECKSUM_EN, send N=1, data 01 02 04 08, checksum 0x0F -> DONE; repeat with checksum 0x0E -> ERR with err=1. In both cases the single write of 0x08040201 has already occurred.
